// File: rtl/bypass_fifo2.sv
// Two-entry FIFO with same-cycle bypass when empty, synchronous flush and a
// sticky protocol-violation flag. Self-contained: no package or sub-modules.
module bypass_fifo2 #(
    parameter int width = 1
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [width-1:0] D_IN,
    input  logic             ENQ,
    output logic             FULL_N,
    output logic [width-1:0] D_OUT,
    input  logic             DEQ,
    output logic             EMPTY_N,
    input  logic             CLR,
    output logic             ERR
);

    logic [1:0]       count;
    logic             head;
    logic             tail;
    logic [width-1:0] mem0;
    logic [width-1:0] mem1;

    logic             enq_ok;
    logic             deq_ok;
    logic             do_enq;
    logic             do_deq;
    logic             violation;

    assign FULL_N  = (count != 2'd2);
    assign EMPTY_N = (count != 2'd0) | ENQ;
    assign D_OUT   = (count == 2'd0) ? D_IN : (head ? mem1 : mem0);

    // When empty, a simultaneous enqueue/dequeue is a pure pass-through:
    // nothing is stored and no pointer moves.
    always_comb begin
        enq_ok    = ENQ & FULL_N;
        deq_ok    = DEQ & EMPTY_N;
        do_enq    = enq_ok & ~((count == 2'd0) & deq_ok);
        do_deq    = deq_ok & (count != 2'd0);
        violation = (ENQ & ~FULL_N) | (DEQ & ~EMPTY_N);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            count <= 2'd0;
            head  <= 1'b0;
            tail  <= 1'b0;
        end else if (CLR) begin
            count <= 2'd0;
            head  <= 1'b0;
            tail  <= 1'b0;
        end else begin
            count <= count + 2'(do_enq) - 2'(do_deq);
            if (do_enq)
                tail <= ~tail;
            if (do_deq)
                head <= ~head;
        end
    end

    // A flush cycle overrides ENQ/DEQ, so it cannot raise a violation.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            ERR <= 1'b0;
        else if (!CLR && violation)
            ERR <= 1'b1;
    end

    // Entry storage is deliberately left out of reset.
    always_ff @(posedge CLK) begin
        if (!CLR && do_enq) begin
            if (tail)
                mem1 <= D_IN;
            else
                mem0 <= D_IN;
        end
    end

endmodule

// File: tb/tb_bypass_fifo2.sv
// Self-checking bench for bypass_fifo2: directed vector table, hand-written
// corner sequences and a randomized run against a queue-based model.
module tb_bypass_fifo2;

    localparam int W = 4;

    logic         CLK = 1'b0;
    logic         RST_N;
    logic [W-1:0] D_IN;
    logic         ENQ;
    logic         DEQ;
    logic         CLR;
    logic [W-1:0] D_OUT;
    logic         FULL_N;
    logic         EMPTY_N;
    logic         ERR;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] modelQ[$];
    logic         modelErr = 1'b0;

    typedef struct {
        logic         enq;
        logic         deq;
        logic         clr;
        logic [W-1:0] din;
        logic         fullN;
        logic         emptyN;
        logic         chkDout;
        logic [W-1:0] dout;
        logic         err;
    } vec_t;

    vec_t vec[14];

    always #5 CLK = ~CLK;

    bypass_fifo2 #(.width(W)) dut (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .D_IN   (D_IN),
        .ENQ    (ENQ),
        .FULL_N (FULL_N),
        .D_OUT  (D_OUT),
        .DEQ    (DEQ),
        .EMPTY_N(EMPTY_N),
        .CLR    (CLR),
        .ERR    (ERR)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, required);
        end
    endtask

    task automatic applyStimulus(input logic enq, input logic deq, input logic clr, input logic [W-1:0] din);
        ENQ  = enq;
        DEQ  = deq;
        CLR  = clr;
        D_IN = din;
        #2;
    endtask

    // Reference behaviour: a FIFO of at most two items, head visible, bypass when empty.
    function automatic void modelUpdate();
        bit fullN;
        bit emptyN;
        bit enqOk;
        bit deqOk;
        fullN  = (modelQ.size() != 2);
        emptyN = (modelQ.size() != 0) || ENQ;
        if (CLR) begin
            modelQ.delete();
        end else begin
            if (ENQ && !fullN) modelErr = 1'b1;
            if (DEQ && !emptyN) modelErr = 1'b1;
            enqOk = ENQ && fullN;
            deqOk = DEQ && emptyN;
            if (modelQ.size() == 0) begin
                if (enqOk && !deqOk) modelQ.push_back(D_IN);
            end else begin
                if (deqOk) void'(modelQ.pop_front());
                if (enqOk) modelQ.push_back(D_IN);
            end
        end
    endfunction

    task automatic checkModel(input string tag);
        logic expEmptyN;
        expEmptyN = (modelQ.size() != 0) || ENQ;
        checkOutput({tag, "_fulln"}, FULL_N, modelQ.size() != 2);
        checkOutput({tag, "_emptyn"}, EMPTY_N, expEmptyN);
        if (expEmptyN)
            checkOutput({tag, "_dout"}, D_OUT, (modelQ.size() == 0) ? D_IN : modelQ[0]);
        checkOutput({tag, "_err"}, ERR, modelErr);
    endtask

    task automatic advance();
        @(posedge CLK);
        modelUpdate();
        #1;
    endtask

    task automatic asyncReset();
        ENQ = 1'b0;
        DEQ = 1'b0;
        CLR = 1'b0;
        #1;
        RST_N = 1'b0;
        modelQ.delete();
        modelErr = 1'b0;
        #1;
        checkModel("rst");
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
    endtask

    initial begin
        // enq deq clr din | fullN emptyN chkDout dout err
        vec[0]  = '{1'b1, 1'b1, 1'b0, 4'h5, 1'b1, 1'b1, 1'b1, 4'h5, 1'b0};
        vec[1]  = '{1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0};
        vec[2]  = '{1'b1, 1'b0, 1'b0, 4'hA, 1'b1, 1'b1, 1'b1, 4'hA, 1'b0};
        vec[3]  = '{1'b1, 1'b0, 1'b0, 4'hB, 1'b1, 1'b1, 1'b1, 4'hA, 1'b0};
        vec[4]  = '{1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 4'hA, 1'b0};
        vec[5]  = '{1'b1, 1'b0, 1'b0, 4'hC, 1'b0, 1'b1, 1'b1, 4'hA, 1'b0};
        vec[6]  = '{1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 4'hA, 1'b1};
        vec[7]  = '{1'b0, 1'b1, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 4'hB, 1'b1};
        vec[8]  = '{1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b1};
        vec[9]  = '{1'b0, 1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b1};
        vec[10] = '{1'b1, 1'b0, 1'b0, 4'h3, 1'b1, 1'b1, 1'b1, 4'h3, 1'b1};
        vec[11] = '{1'b1, 1'b0, 1'b0, 4'h4, 1'b1, 1'b1, 1'b1, 4'h3, 1'b1};
        vec[12] = '{1'b1, 1'b1, 1'b1, 4'h7, 1'b0, 1'b1, 1'b1, 4'h3, 1'b1};
        vec[13] = '{1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b1};

        RST_N = 1'b0;
        ENQ   = 1'b0;
        DEQ   = 1'b0;
        CLR   = 1'b0;
        D_IN  = '0;
        repeat (2) @(posedge CLK);
        #1;
        RST_N = 1'b1;

        #2;
        checkOutput("reset_fulln", FULL_N, 1'b1);
        checkOutput("reset_emptyn", EMPTY_N, 1'b0);
        checkOutput("reset_err", ERR, 1'b0);
        advance();

        $display("[TB] directed vector table");
        for (int i = 0; i < 14; i++) begin
            applyStimulus(vec[i].enq, vec[i].deq, vec[i].clr, vec[i].din);
            checkOutput($sformatf("vec%0d_fulln", i), FULL_N, vec[i].fullN);
            checkOutput($sformatf("vec%0d_emptyn", i), EMPTY_N, vec[i].emptyN);
            if (vec[i].chkDout)
                checkOutput($sformatf("vec%0d_dout", i), D_OUT, vec[i].dout);
            checkOutput($sformatf("vec%0d_err", i), ERR, vec[i].err);
            advance();
        end

        $display("[TB] steady stream with pointer wrap");
        asyncReset();
        applyStimulus(1'b1, 1'b0, 1'b0, 4'h1);
        advance();
        for (int v = 2; v <= 9; v++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, W'(v));
            checkOutput($sformatf("stream%0d_dout", v), D_OUT, v - 1);
            checkOutput($sformatf("stream%0d_fulln", v), FULL_N, 1'b1);
            checkOutput($sformatf("stream%0d_emptyn", v), EMPTY_N, 1'b1);
            checkOutput($sformatf("stream%0d_err", v), ERR, 1'b0);
            advance();
        end

        $display("[TB] asynchronous reset while full");
        applyStimulus(1'b1, 1'b0, 1'b0, 4'hC);
        advance();
        applyStimulus(1'b0, 1'b0, 1'b0, 4'h0);
        checkOutput("full_fulln", FULL_N, 1'b0);
        checkOutput("full_dout", D_OUT, 4'h9);
        applyStimulus(1'b1, 1'b0, 1'b0, 4'hD);
        advance();
        applyStimulus(1'b0, 1'b0, 1'b0, 4'h0);
        checkOutput("ovf_err", ERR, 1'b1);
        checkOutput("ovf_dout", D_OUT, 4'h9);
        RST_N = 1'b0;
        modelQ.delete();
        modelErr = 1'b0;
        #1;
        checkOutput("arst_fulln", FULL_N, 1'b1);
        checkOutput("arst_emptyn", EMPTY_N, 1'b0);
        checkOutput("arst_err", ERR, 1'b0);
        ENQ  = 1'b1;
        D_IN = 4'h6;
        #1;
        checkOutput("arst_bypass_emptyn", EMPTY_N, 1'b1);
        checkOutput("arst_bypass_dout", D_OUT, 4'h6);
        ENQ = 1'b0;
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 4'h0);
        checkOutput("post_rst_emptyn", EMPTY_N, 1'b0);
        checkOutput("post_rst_fulln", FULL_N, 1'b1);
        advance();

        $display("[TB] randomized run against reference model");
        for (int i = 0; i < 1500; i++) begin
            if (i % 300 == 299)
                asyncReset();
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 15) == 0), W'($urandom));
            checkModel($sformatf("rand%0d", i));
            advance();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
